// File: rtl/jmp_instruction_unit.sv
// Program counter with sequential, jump, zero-flag branch and call/return flow.
// Return addresses live in a small LIFO stack; overflow/underflow are sticky until reset.
module jmp_instruction_unit #(
  parameter int                 ADDR_W      = 19,
  parameter int                 STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_SEQ  = 3'b000,
    OP_JMP  = 3'b001,
    OP_JZ   = 3'b010,
    OP_JNZ  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_HOLD = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] pc_inc;
  logic              push;
  logic              pop;
  logic              set_ovf;
  logic              set_unf;

  assign stack_full  = (count == FULL_CNT);
  assign stack_empty = (count == '0);
  assign top_idx     = PTR_W'(count - 1'b1);
  assign pc_inc      = pc + 1'b1;

  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (en) begin
      case (op_e'(op))
        OP_JMP:  pc_next = jmp_addr;
        OP_JZ:   pc_next = zero_flag ? jmp_addr : pc_inc;
        OP_JNZ:  pc_next = zero_flag ? pc_inc : jmp_addr;
        OP_CALL: begin
          // A call into a full stack degrades to a plain increment.
          if (stack_full) begin
            pc_next = pc_inc;
            set_ovf = 1'b1;
          end else begin
            pc_next = jmp_addr;
            push    = 1'b1;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            pc_next = pc_inc;
            set_unf = 1'b1;
          end else begin
            pc_next = stack_mem[top_idx];
            pop     = 1'b1;
          end
        end
        OP_HOLD: pc_next = pc;
        default: pc_next = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (en) begin
      pc        <= pc_next;
      overflow  <= overflow | set_ovf;
      underflow <= underflow | set_unf;
      if (push)     count <= count + 1'b1;
      else if (pop) count <= count - 1'b1;
    end
  end

  // Contents need no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push) stack_mem[count[PTR_W-1:0]] <= pc_inc;
  end

endmodule

// File: tb/tb_jmp_instruction_unit.sv
// Bench for jmp_instruction_unit: reference model feeds an expected queue that is
// checked one edge later; pc_next is checked combinationally before each edge.
module tb_jmp_instruction_unit;

  localparam int ADDR_W = 19;
  localparam int DEPTH  = 8;
  localparam int W      = ADDR_W + 4;

  logic              clk;
  logic              rst;
  logic              en;
  logic [2:0]        op;
  logic [ADDR_W-1:0] jmp_addr;
  logic              zero_flag;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              stack_full;
  logic              stack_empty;
  logic              overflow;
  logic              underflow;

  jmp_instruction_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .jmp_addr(jmp_addr),
    .zero_flag(zero_flag), .pc(pc), .pc_next(pc_next),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .overflow(overflow), .underflow(underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]      exp_q[$];
  logic [ADDR_W-1:0] m_stk[$];
  logic [ADDR_W-1:0] m_pc;
  logic              m_ovf;
  logic              m_unf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_stk.delete();
  endtask

  // driver: one cycle of stimulus, model update, scoreboard push/pop
  task automatic step(input logic r, input logic e, input logic [2:0] o,
                      input logic [ADDR_W-1:0] a, input logic z);
    logic [ADDR_W-1:0] inc, nxt;
    logic              do_push, do_pop, s_ovf, s_unf;
    logic [W-1:0]      got, exp;
    @(negedge clk);
    rst = r; en = e; op = o; jmp_addr = a; zero_flag = z;
    inc = m_pc + 1'b1;
    nxt = m_pc; do_push = 0; do_pop = 0; s_ovf = 0; s_unf = 0;
    if (e) begin
      case (o)
        3'd1: nxt = a;
        3'd2: nxt = z ? a : inc;
        3'd3: nxt = z ? inc : a;
        3'd4: if (m_stk.size() == DEPTH) begin nxt = inc; s_ovf = 1; end
              else begin nxt = a; do_push = 1; end
        3'd5: if (m_stk.size() == 0) begin nxt = inc; s_unf = 1; end
              else begin nxt = m_stk[$]; do_pop = 1; end
        3'd6: nxt = m_pc;
        default: nxt = inc;
      endcase
    end
    #1 chk("pc_next", 32'(pc_next), 32'(nxt));
    if (r) model_reset();
    else if (e) begin
      if (do_push) m_stk.push_back(inc);
      if (do_pop)  void'(m_stk.pop_back());
      m_ovf = m_ovf | s_ovf;
      m_unf = m_unf | s_unf;
      m_pc  = nxt;
    end
    exp_q.push_back({m_pc, m_stk.size() == DEPTH, m_stk.size() == 0, m_ovf, m_unf});
    @(posedge clk);
    #1;
    got = {pc, stack_full, stack_empty, overflow, underflow};
    exp = exp_q.pop_front();
    chk("pc", 32'(got[W-1:4]), 32'(exp[W-1:4]));
    chk("flags", 32'(got[3:0]), 32'(exp[3:0]));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = 3'd0; jmp_addr = '0; zero_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_flags", {28'd0, stack_full, stack_empty, overflow, underflow}, 32'b0100);

    for (int i = 0; i < 3; i++) step(0, 1, 3'd0, 19'h1234, 0);
    chk("seq3", 32'(pc), 32'd3);

    step(0, 1, 3'd1, 19'd450, 0);
    chk("jmp450", 32'(pc), 32'd450);
    step(0, 0, 3'd1, 19'd999, 0);
    chk("hold_en0", 32'(pc), 32'd450);

    step(0, 1, 3'd2, 19'd1000, 0);
    chk("jz_nt", 32'(pc), 32'd451);
    step(0, 1, 3'd2, 19'd1000, 1);
    chk("jz_t", 32'(pc), 32'd1000);
    step(0, 1, 3'd3, 19'd5, 1);
    chk("jnz_nt", 32'(pc), 32'd1001);

    step(0, 1, 3'd1, 19'd10, 0);
    step(0, 1, 3'd4, 19'h100, 0);
    chk("call", 32'(pc), 32'h100);
    step(0, 1, 3'd0, 19'd0, 0);
    step(0, 1, 3'd0, 19'd0, 0);
    chk("seq_after_call", 32'(pc), 32'h102);
    step(0, 1, 3'd5, 19'h7777, 0);
    chk("ret", 32'(pc), 32'd11);
    chk("ret_empty", 32'(stack_empty), 32'd1);

    for (int i = 0; i < 60; i++)
      step(0, ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           19'($urandom_range(0, 19'h7FFFF)), 1'($urandom_range(0, 1)));

    step(1, 1, 3'd0, 19'd0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 3'd4, 19'(100 + 10 * i), 0);
    chk("full", 32'(stack_full), 32'd1);
    step(0, 1, 3'd4, 19'd7, 0);
    chk("ovf_pc", 32'(pc), 32'd171);
    chk("ovf", 32'(overflow), 32'd1);
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 1, 3'd5, 19'd0, 0);
      chk("ret_order", 32'(pc), (k < DEPTH - 1) ? 32'(161 - 10 * k) : 32'd1);
    end
    step(0, 1, 3'd5, 19'd0, 0);
    chk("unf_pc", 32'(pc), 32'd2);
    chk("unf", 32'(underflow), 32'd1);

    step(0, 1, 3'd1, 19'h7FFFF, 0);
    step(0, 1, 3'd0, 19'd0, 0);
    chk("wrap_seq", 32'(pc), 32'd0);
    step(0, 1, 3'd1, 19'h7FFFF, 0);
    step(0, 1, 3'd4, 19'd20, 0);
    chk("wrap_call", 32'(pc), 32'd20);
    step(0, 1, 3'd5, 19'd0, 0);
    chk("wrap_ret", 32'(pc), 32'd0);

    step(0, 1, 3'd4, 19'd30, 0);
    step(1, 1, 3'd1, 19'd450, 0);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_flags", {28'd0, stack_full, stack_empty, overflow, underflow}, 32'b0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jmp_instruction_unit.md
Name: jmp_instruction_unit

Overview:
- Program-counter / control-flow unit for the 19-bit-address core.
- Holds the registered PC and computes the next PC each enabled cycle: sequential increment, unconditional jump, zero-flag conditional jumps, and call/return through an internal return-address stack.
- Sits between the instruction decoder, which supplies the opcode, target address and flag, and the instruction fetch, which consumes pc.

Parameters:
- ADDR_W, 19, width of jmp_addr, pc, pc_next and the stack entries.
- STACK_DEPTH, 8, number of return-address stack entries (power of two, at least 2).
- RESET_PC, 0, value loaded into pc on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance enable; when 0, all state holds.
- op  input  3  control-flow opcode (encoding below).
- jmp_addr  input  ADDR_W  jump or call target address.
- zero_flag  input  1  ALU zero flag for JZ and JNZ.
- pc  output  ADDR_W  registered program counter.
- pc_next  output  ADDR_W  combinational value pc will take at the next enabled edge.
- stack_full  output  1  stack holds STACK_DEPTH entries.
- stack_empty  output  1  stack holds 0 entries.
- overflow  output  1  sticky flag: CALL attempted while full.
- underflow  output  1  sticky flag: RET attempted while empty.

Behaviour:
- Reset: the clock and reset are one clock, reset synchronous and active-high, as already decided. At a rising edge with rst=1: pc=RESET_PC, stack count=0, overflow=0, underflow=0. Stack contents are don't-care. rst has priority over en and op.
- Opcodes:
  - 000 SEQ: pc_next = pc+1.
  - 001 JMP: pc_next = jmp_addr.
  - 010 JZ: jmp_addr if zero_flag=1, else pc+1.
  - 011 JNZ: jmp_addr if zero_flag=0, else pc+1.
  - 100 CALL: push pc+1, then pc_next = jmp_addr.
  - 101 RET: pop, pc_next = popped entry.
  - 110 HOLD: pc_next = pc.
  - 111 reserved: behaves as SEQ.
- Latency: pc updates at the first rising edge after the inputs are presented (1 cycle). pc_next is purely combinational from pc, op, jmp_addr, zero_flag and the stack state.
- en=0: pc_next = pc. No push, pop or flag change occurs.
- Arithmetic: pc+1 is modulo 2^ADDR_W, so all-ones wraps to 0. The pushed return address follows the same wrap rule.
- CALL while stack_full: no push, no jump. pc_next = pc+1 and overflow is set.
- RET while stack_empty: no pop. pc_next = pc+1 and underflow is set.
- overflow and underflow stay set until rst.
- Stack is LIFO. stack_full and stack_empty are derived from the registered count and reflect the state after the last edge.
- jmp_addr is ignored by SEQ, HOLD and RET.

Test Plan:
- Apply rst=1 for 2 cycles, then en=1, op=SEQ for 3 cycles -> pc 0,1,2,3; stack_empty=1; overflow=0; underflow=0.
- Set jmp_addr=450, op=JMP, en=1 -> pc_next=450 in the same cycle; pc=450 after 1 edge. Repeat with en=0 -> pc holds.
- With pc=450: JZ target 1000 with zero_flag=0 -> pc=451. JZ target 1000 with zero_flag=1 -> pc=1000. JNZ target 5 with zero_flag=1 -> pc=1001.
- CALL 0x100 from pc=10, then SEQ x2, then RET -> pc goes 0x100, 0x101, 0x102, then 11; stack_empty=1 again.
- Perform 8 CALLs (full), then a 9th CALL target 7 -> no jump (pc+1), overflow=1, stack_full=1. Then 9 RETs -> 8 return addresses in reverse order; the 9th RET gives pc+1 and sets underflow=1.
- With pc=0x7FFFF: SEQ -> pc=0. Assert rst mid-sequence with op=JMP, jmp_addr=450 -> pc=0, flags cleared, stack emptied.
